button_frontend: RTL and testbench

Input-conditioning stage directly upstream of the blackjack game core. It takes the four raw, asynchronous, bouncy push-button levels (hit, stand, double, start) and resynchronises each one. Each button is debounced, and the block emits a single-cycle, mutually exclusive action pulse per accepted press. It also derives the RNG seed from a free-running counter, so entropy comes from the player's timing, and issues a one-time seed load coincident with the first accepted start press after reset.

---
 rtl/button_frontend.sv | 113 +++++++++++
 tb/tb_button_frontend.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/button_frontend.sv
// Button conditioning for the blackjack core: 2-flop sync, per-button debounce,
// prioritised one-shot press pulses and one-time RNG seed capture on first start.
module button_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        raw_hit,
  input  logic        raw_stand,
  input  logic        raw_double,
  input  logic        raw_start,
  output logic        btn_hit,
  output logic        btn_stand,
  output logic        btn_double,
  output logic        btn_start,
  output logic        rng_load,
  output logic [15:0] rng_seed,
  output logic [3:0]  db_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: {start, double, stand, hit}
  logic [3:0]       raw;
  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       stable;
  logic [3:0]       press;
  logic [3:0]       grant;
  logic [CNT_W-1:0] cnt [4];
  logic [15:0]      seed_cnt;
  logic             seeded;

  assign raw      = {raw_start, raw_double, raw_stand, raw_hit};
  assign db_level = stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is the edge at which a stable bit is about to flip 0 -> 1.
  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      press[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST) && s2[i];
    end
  end

  // Priority stand > double > hit > start; losers are dropped.
  always_comb begin
    grant = '0;
    if (press[1])      grant[1] = 1'b1;
    else if (press[2]) grant[2] = 1'b1;
    else if (press[0]) grant[0] = 1'b1;
    else if (press[3]) grant[3] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_hit    <= 1'b0;
      btn_stand  <= 1'b0;
      btn_double <= 1'b0;
      btn_start  <= 1'b0;
    end else begin
      btn_hit    <= grant[0];
      btn_stand  <= grant[1];
      btn_double <= grant[2];
      btn_start  <= grant[3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_cnt <= '0;
      seeded   <= 1'b0;
      rng_load <= 1'b0;
      rng_seed <= '0;
    end else begin
      seed_cnt <= seed_cnt + 16'd1;
      rng_load <= grant[3] && !seeded;
      if (grant[3] && !seeded) begin
        rng_seed <= (seed_cnt == 16'd0) ? 16'hACE1 : seed_cnt;
        seeded   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_frontend.sv
// Scoreboard bench for button_frontend: directed scenarios plus random bouncy
// stimulus, checked against a sliding-window reference model.
module tb_button_frontend;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        raw_hit = 1'b0;
  logic        raw_stand = 1'b0;
  logic        raw_double = 1'b0;
  logic        raw_start = 1'b0;
  logic        btn_hit;
  logic        btn_stand;
  logic        btn_double;
  logic        btn_start;
  logic        rng_load;
  logic [15:0] rng_seed;
  logic [3:0]  db_level;

  button_frontend #(.DEBOUNCE_CYCLES(D), .CNT_W(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .raw_hit(raw_hit), .raw_stand(raw_stand), .raw_double(raw_double), .raw_start(raw_start),
    .btn_hit(btn_hit), .btn_stand(btn_stand), .btn_double(btn_double), .btn_start(btn_start),
    .rng_load(rng_load), .rng_seed(rng_seed), .db_level(db_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  btn;   // {start, double, stand, hit}
    logic        load;
    logic [15:0] seed;
    logic [3:0]  db;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: raw sample history per button (bit j = sample j edges ago)
  bit [15:0]   hist [4];
  bit [3:0]    m_stable;
  bit          m_seeded;
  bit [15:0]   m_seed;
  int unsigned m_edge;

  task automatic step(input bit rst, input bit [3:0] raw);
    exp_t e;
    bit [3:0] pr;
    int win;
    int prio [4];
    @(negedge clk);
    rst_n = rst;
    {raw_start, raw_double, raw_stand, raw_hit} = raw;
    if (!rst) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      m_stable = '0;
      m_seeded = 1'b0;
      m_seed   = '0;
      m_edge   = 0;
      e = '0;
      exp_q.push_back(e);
      return;
    end
    m_edge++;
    pr = '0;
    for (int i = 0; i < 4; i++) begin
      bit v;
      bit all_same;
      hist[i] = {hist[i][14:0], raw[i]};
      // A level is accepted once the synchronised value has held for D edges
      v = hist[i][2];
      all_same = 1'b1;
      for (int j = 2; j <= int'(D) + 1; j++) if (hist[i][j] != v) all_same = 1'b0;
      if (all_same && v != m_stable[i]) begin
        m_stable[i] = v;
        if (v) pr[i] = 1'b1;
      end
    end
    prio = '{1, 2, 0, 3};
    win = -1;
    for (int k = 0; k < 4; k++) if (win < 0 && pr[prio[k]]) win = prio[k];
    e = '0;
    if (win >= 0) e.btn[win] = 1'b1;
    if (win == 3 && !m_seeded) begin
      e.load   = 1'b1;
      m_seed   = 16'((m_edge - 1) % 65536);
      if (m_seed == 16'd0) m_seed = 16'hACE1;
      m_seeded = 1'b1;
    end
    e.seed = m_seed;
    e.db   = m_stable;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input bit [3:0] raw);
    for (int i = 0; i < n; i++) step(1'b1, raw);
  endtask

  // Monitor: one scoreboard entry per clock edge
  initial begin
    exp_t want;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {btn_start, btn_double, btn_stand, btn_hit, rng_load, rng_seed, db_level};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL outputs t=%0t got btn=%b load=%b seed=%h db=%b want btn=%b load=%b seed=%h db=%b",
                   $time, got.btn, got.load, got.seed, got.db,
                   want.btn, want.load, want.seed, want.db);
        end
      end
    end
  end

  initial begin
    bit [3:0] r;
    bit rs;
    repeat (3) step(1'b0, 4'b0000);
    // clean press and release on hit
    hold(20, 4'b0001);
    hold(12, 4'b0000);
    // bouncing stand
    hold(3, 4'b0010);
    hold(1, 4'b0000);
    hold(15, 4'b0010);
    hold(12, 4'b0000);
    // simultaneous hit/double/start: double wins, no seed
    hold(12, 4'b1101);
    hold(12, 4'b0000);
    // seeding at counter 0x0123, then a second start press
    repeat (2) step(1'b0, 4'b0000);
    while (m_edge < 286) step(1'b1, 4'b0000);
    hold(10, 4'b1000);
    hold(12, 4'b0000);
    hold(10, 4'b1000);
    hold(12, 4'b0000);
    // zero-seed substitution after counter wrap
    repeat (2) step(1'b0, 4'b0000);
    while (m_edge < 65531) step(1'b1, 4'b0000);
    hold(10, 4'b1000);
    hold(12, 4'b0000);
    // reset mid-count on held hit, then release with hit still held
    hold(4, 4'b0001);
    repeat (2) step(1'b0, 4'b0001);
    hold(12, 4'b0001);
    hold(12, 4'b0000);
    // random bouncy stimulus with occasional resets
    r = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      rs = ($urandom_range(0, 499) != 0);
      step(rs, r);
    end
    hold(12, 4'b0000);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
